mmio_fabric: RTL and testbench

Parametrised MMIO interconnect between the memory controller's MMIO port and N peripheral slaves. It generalises the fixed two-way SPI/peripheral mux in the top level to any slave count with per-slave base/mask decode. It adds registered decode, a bus timeout watchdog and an error response for unmapped addresses. It sits between `mem_controller` (`mmio_*` port) and the peripherals: `mmio_peripherals`, `spi_master` and future blocks.

---
 rtl/mmio_fabric_pkg.sv | 32 +++
 rtl/mmio_addr_decoder.sv | 30 +++
 rtl/mmio_fabric.sv | 200 ++++++++++++++++++++
 tb/tb_mmio_fabric.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_fabric_pkg.sv
// Shared constants, FSM encodings and request payload for the MMIO fabric.
package mmio_fabric_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned ERR_W   = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCESS = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP   = 2'd2;

  localparam logic [ERR_W-1:0] ERR_NONE     = 2'd0;
  localparam logic [ERR_W-1:0] ERR_UNMAPPED = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 2'd2;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mmio_req_t;

  // Binary select width; a single-slave fabric still carries one index bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmio_addr_decoder.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module mmio_addr_decoder
  import mmio_fabric_pkg::*;
#(
  parameter int unsigned                 NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK = '0,
  localparam int unsigned                IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  hit_o,
  output logic [NUM_SLAVES-1:0] sel_oh_o,
  output logic [IDX_W-1:0]      sel_idx_o
);

  // Scan from the top down so that lower indices overwrite higher ones.
  always_comb begin
    hit_o     = 1'b0;
    sel_oh_o  = '0;
    sel_idx_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit_o     = 1'b1;
        sel_oh_o  = NUM_SLAVES'(1) << i;
        sel_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_fabric.sv
// MMIO interconnect: registered decode to N slaves, watchdog timeout and
// sticky error reporting for unmapped or unresponsive accesses.
module mmio_fabric
  import mmio_fabric_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'h80002000, 32'h80001000,
                                                        32'h80000000, 32'h80000050},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {32'hFFFFF000, 32'hFFFFF000,
                                                        32'hFFFFFF00, 32'hFFFFFFF0},
  parameter int unsigned              TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m_valid,
  input  logic                     m_write,
  input  logic [ADDR_W-1:0]        m_addr,
  input  logic [DATA_W-1:0]        m_wdata,
  input  logic [STRB_W-1:0]        m_wstrb,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     m_ready,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic                     s_write,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [STRB_W-1:0]        s_wstrb,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic                     err_irq,
  output logic [ERR_W-1:0]         err_code,
  output logic [ADDR_W-1:0]        err_addr,
  input  logic                     err_clr
);

  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [STATE_W-1:0]    state_q, state_d;
  mmio_req_t             req_q, req_d;
  logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
  logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     m_rdata_q, m_rdata_d;
  logic                  m_ready_q, m_ready_d;
  logic                  err_irq_q, err_irq_d;
  logic [ERR_W-1:0]      err_code_q, err_code_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;

  logic                  dec_hit_c;
  logic [NUM_SLAVES-1:0] dec_oh_c;
  logic [IDX_W-1:0]      dec_idx_c;
  logic                  sel_ready_c;
  logic [DATA_W-1:0]     sel_rdata_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic                  timeout_c;
  logic                  new_err_c;
  logic [ERR_W-1:0]      new_code_c;
  logic [ADDR_W-1:0]     new_addr_c;

  mmio_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr_i    (m_addr),
    .hit_o     (dec_hit_c),
    .sel_oh_o  (dec_oh_c),
    .sel_idx_o (dec_idx_c)
  );

  // Only the selected slave's ready/rdata are observed.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_rdata_c = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx_q == IDX_W'(i)) begin
        sel_ready_c = s_ready[i];
        sel_rdata_c = s_rdata[i*32 +: 32];
      end
    end
  end

  // Counter value including the current ACCESS cycle, saturating.
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_inc_c == CNT_LIMIT);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    sel_idx_d  = sel_idx_q;
    s_valid_d  = s_valid_q;
    cnt_d      = cnt_q;
    m_rdata_d  = m_rdata_q;
    m_ready_d  = 1'b0;
    err_irq_d  = 1'b0;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    new_err_c  = 1'b0;
    new_code_c = ERR_NONE;
    new_addr_c = req_q.addr;

    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          req_d.write = m_write;
          req_d.addr  = m_addr;
          req_d.wdata = m_wdata;
          req_d.wstrb = m_wstrb;
          if (dec_hit_c) begin
            state_d   = ST_ACCESS;
            sel_idx_d = dec_idx_c;
            s_valid_d = dec_oh_c;
            cnt_d     = '0;
          end else begin
            state_d    = ST_RESP;
            m_ready_d  = 1'b1;
            m_rdata_d  = ERR_DATA;
            new_err_c  = 1'b1;
            new_code_c = ERR_UNMAPPED;
            new_addr_c = m_addr;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_inc_c;
        if (sel_ready_c) begin
          state_d   = ST_RESP;
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_rdata_d = sel_rdata_c;
        end else if (timeout_c) begin
          state_d    = ST_RESP;
          s_valid_d  = '0;
          m_ready_d  = 1'b1;
          m_rdata_d  = ERR_DATA;
          new_err_c  = 1'b1;
          new_code_c = ERR_TIMEOUT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        s_valid_d = '0;
      end
    endcase

    // First error is sticky; a clear coinciding with a new error keeps the new one.
    err_irq_d = new_err_c;
    if (new_err_c && ((err_code_q == ERR_NONE) || err_clr)) begin
      err_code_d = new_code_c;
      err_addr_d = new_addr_c;
    end else if (err_clr) begin
      err_code_d = ERR_NONE;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      sel_idx_q  <= '0;
      s_valid_q  <= '0;
      cnt_q      <= '0;
      m_rdata_q  <= '0;
      m_ready_q  <= 1'b0;
      err_irq_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      sel_idx_q  <= sel_idx_d;
      s_valid_q  <= s_valid_d;
      cnt_q      <= cnt_d;
      m_rdata_q  <= m_rdata_d;
      m_ready_q  <= m_ready_d;
      err_irq_q  <= err_irq_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m_rdata  = m_rdata_q;
  assign m_ready  = m_ready_q;
  assign s_valid  = s_valid_q;
  assign s_write  = req_q.write;
  assign s_addr   = req_q.addr;
  assign s_wdata  = req_q.wdata;
  assign s_wstrb  = req_q.wstrb;
  assign err_irq  = err_irq_q;
  assign err_code = err_code_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed bench for mmio_fabric: decode, priority, unmapped, timeout, write and reset.
module tb_mmio_fabric;

  localparam int unsigned NS = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_write = 1'b0;
  logic [31:0]   m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic [3:0]    m_wstrb = '0;
  logic [31:0]   m_rdata;
  logic          m_ready;
  logic [NS-1:0] s_valid;
  logic          s_write;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic [NS*32-1:0] s_rdata = '0;
  logic [NS-1:0] s_ready = '0;
  logic          err_irq;
  logic [1:0]    err_code;
  logic [31:0]   err_addr;
  logic          err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  mmio_fabric #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     ({32'h80002000, 32'h80001000, 32'h80000000, 32'h80000050}),
    .SLAVE_MASK     ({32'hFFFFF000, 32'hFFFFF000, 32'hFFFFFF00, 32'hFFFFFFF0}),
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m_valid  (m_valid),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .s_valid  (s_valid),
    .s_write  (s_write),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err_irq  (err_irq),
    .err_code (err_code),
    .err_addr (err_addr),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // Next cycle becomes cycle 0 of a new request.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
    @(posedge clk); #1;
    m_write = wr; m_addr = addr; m_wdata = wd; m_wstrb = st; m_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_ready !== 1'b0 || m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m: ready=%b rdata=%h want 0/0", m_ready, m_rdata); end
    checks++; if (s_valid !== 4'b0 || s_addr !== 32'h0 || s_write !== 1'b0) begin errors++; $display("FAIL reset_s: valid=%b addr=%h wr=%b want 0", s_valid, s_addr, s_write); end
    checks++; if (err_irq !== 1'b0 || err_code !== 2'd0 || err_addr !== 32'h0) begin errors++; $display("FAIL reset_err: irq=%b code=%0d addr=%h want 0", err_irq, err_code, err_addr); end
    resetn = 1'b1;
  endtask

  task automatic test_read_hit();
    issue(1'b0, 32'h80000054, 32'h0, 4'h0);
    step();
    checks++; if (s_valid !== 4'b0001 || m_ready !== 1'b0) begin errors++; $display("FAIL hit_c1: s_valid=%b m_ready=%b want 0001/0", s_valid, m_ready); end
    checks++; if (s_addr !== 32'h80000054) begin errors++; $display("FAIL hit_addr: got %h want 80000054", s_addr); end
    step();
    checks++; if (s_valid !== 4'b0001 || m_ready !== 1'b0) begin errors++; $display("FAIL hit_c2: s_valid=%b m_ready=%b want 0001/0", s_valid, m_ready); end
    s_ready = 4'b0001; s_rdata[31:0] = 32'h12345678;
    step();
    checks++; if (m_ready !== 1'b1 || m_rdata !== 32'h12345678 || s_valid !== 4'b0) begin errors++; $display("FAIL hit_c3: ready=%b rdata=%h s_valid=%b want 1/12345678/0000", m_ready, m_rdata, s_valid); end
    m_valid = 1'b0; s_ready = '0;
    step();
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL hit_pulse: m_ready=%b want 0", m_ready); end
  endtask

  task automatic test_priority();
    issue(1'b0, 32'h80000050, 32'h0, 4'h0);
    step();
    checks++; if (s_valid !== 4'b0001) begin errors++; $display("FAIL prio_overlap: s_valid=%b want 0001", s_valid); end
    s_ready = 4'b0010;
    step();
    checks++; if (s_valid !== 4'b0001 || m_ready !== 1'b0) begin errors++; $display("FAIL prio_ignore: s_valid=%b m_ready=%b want 0001/0", s_valid, m_ready); end
    s_ready = 4'b0001; s_rdata[31:0] = 32'h11111111; s_rdata[63:32] = 32'h22222222;
    step();
    checks++; if (m_ready !== 1'b1 || m_rdata !== 32'h11111111) begin errors++; $display("FAIL prio_data: ready=%b rdata=%h want 1/11111111", m_ready, m_rdata); end
    m_valid = 1'b0; s_ready = '0;
    issue(1'b0, 32'h80000010, 32'h0, 4'h0);
    step();
    checks++; if (s_valid !== 4'b0010) begin errors++; $display("FAIL prio_slave1: s_valid=%b want 0010", s_valid); end
    s_ready = 4'b0010; s_rdata[63:32] = 32'hCAFEF00D;
    step();
    checks++; if (m_ready !== 1'b1 || m_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL min_latency: ready=%b rdata=%h want 1/cafef00d", m_ready, m_rdata); end
    m_valid = 1'b0; s_ready = '0;
  endtask

  task automatic test_unmapped();
    issue(1'b0, 32'h90000000, 32'h0, 4'h0);
    step();
    checks++; if (m_ready !== 1'b1 || m_rdata !== 32'hDEADBEEF || s_valid !== 4'b0) begin errors++; $display("FAIL unmap_resp: ready=%b rdata=%h s_valid=%b want 1/deadbeef/0000", m_ready, m_rdata, s_valid); end
    checks++; if (err_irq !== 1'b1 || err_code !== 2'd1 || err_addr !== 32'h90000000) begin errors++; $display("FAIL unmap_err: irq=%b code=%0d addr=%h want 1/1/90000000", err_irq, err_code, err_addr); end
    m_valid = 1'b0;
    step();
    checks++; if (err_irq !== 1'b0 || err_code !== 2'd1 || m_ready !== 1'b0) begin errors++; $display("FAIL unmap_sticky: irq=%b code=%0d ready=%b want 0/1/0", err_irq, err_code, m_ready); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_code !== 2'd0 || err_addr !== 32'h0) begin errors++; $display("FAIL unmap_clr: code=%0d addr=%h want 0/0", err_code, err_addr); end
  endtask

  task automatic test_timeout();
    int hi_cnt = 0;
    int resp_cyc = 0;
    issue(1'b0, 32'h80001004, 32'h0, 4'h0);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (m_ready === 1'b1) begin resp_cyc = c; break; end
      if (s_valid === 4'b0100) hi_cnt++;
    end
    checks++; if (hi_cnt != 8 || resp_cyc != 9) begin errors++; $display("FAIL to_timing: s_valid cycles=%0d ready cycle=%0d want 8/9", hi_cnt, resp_cyc); end
    checks++; if (m_rdata !== 32'hDEADBEEF || s_valid !== 4'b0) begin errors++; $display("FAIL to_resp: rdata=%h s_valid=%b want deadbeef/0000", m_rdata, s_valid); end
    checks++; if (err_irq !== 1'b1 || err_code !== 2'd2 || err_addr !== 32'h80001004) begin errors++; $display("FAIL to_err: irq=%b code=%0d addr=%h want 1/2/80001004", err_irq, err_code, err_addr); end
    m_valid = 1'b0;
    issue(1'b0, 32'hA0000000, 32'h0, 4'h0);
    step();
    checks++; if (err_irq !== 1'b1 || err_code !== 2'd2 || err_addr !== 32'h80001004) begin errors++; $display("FAIL second_err_kept: irq=%b code=%0d addr=%h want 1/2/80001004", err_irq, err_code, err_addr); end
    m_valid = 1'b0;
    issue(1'b0, 32'hB0000000, 32'h0, 4'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; m_valid = 1'b0;
    checks++; if (err_code !== 2'd1 || err_addr !== 32'hB0000000) begin errors++; $display("FAIL clr_with_err: code=%0d addr=%h want 1/b0000000", err_code, err_addr); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_code !== 2'd0 || err_addr !== 32'h0) begin errors++; $display("FAIL to_clr: code=%0d addr=%h want 0/0", err_code, err_addr); end
  endtask

  task automatic test_write();
    int pulses = 0;
    int stable_bad = 0;
    issue(1'b1, 32'h80000020, 32'h000000A5, 4'b0001);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (m_ready === 1'b1) begin pulses++; m_valid = 1'b0; end
      if (c <= 3 && (s_valid !== 4'b0010 || s_write !== 1'b1 || s_wdata !== 32'hA5 || s_wstrb !== 4'b0001)) stable_bad++;
      s_ready = (c == 3) ? 4'b0010 : 4'b0000;
      if (c == 4) begin
        checks++; if (m_ready !== 1'b1 || s_valid !== 4'b0) begin errors++; $display("FAIL wr_resp: ready=%b s_valid=%b want 1/0000", m_ready, s_valid); end
      end
    end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL wr_stable: bad cycles=%0d want 0", stable_bad); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h90000004, 32'h0, 4'h0);
    step();
    m_valid = 1'b0;
    issue(1'b0, 32'h80000058, 32'h0, 4'h0);
    step();
    checks++; if (s_valid !== 4'b0001 || err_code !== 2'd1) begin errors++; $display("FAIL rst_pre: s_valid=%b code=%0d want 0001/1", s_valid, err_code); end
    step();
    step();
    resetn = 1'b0; m_valid = 1'b0;
    #1;
    checks++; if (s_valid !== 4'b0 || m_ready !== 1'b0 || m_rdata !== 32'h0 || s_addr !== 32'h0) begin errors++; $display("FAIL rst_async: s_valid=%b ready=%b rdata=%h addr=%h want 0", s_valid, m_ready, m_rdata, s_addr); end
    checks++; if (err_code !== 2'd0 || err_addr !== 32'h0) begin errors++; $display("FAIL rst_err: code=%0d addr=%h want 0/0", err_code, err_addr); end
    #3 resetn = 1'b1;
    issue(1'b0, 32'h80000010, 32'h0, 4'h0);
    step();
    s_ready = 4'b0010; s_rdata[63:32] = 32'h0BADF00D;
    step();
    checks++; if (m_ready !== 1'b1 || m_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rst_after: ready=%b rdata=%h want 1/0badf00d", m_ready, m_rdata); end
    m_valid = 1'b0; s_ready = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_priority();
    test_unmapped();
    test_timeout();
    test_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
